audio_key_controller: RTL

Parametrised keyboard command controller for the DE1-SoC audio player. It decodes PS/2 scan codes into play/pause, direction, restart and playback-speed commands. It also generates the sample-rate tick that paces the flash-read/audio-output path. It sits between the keyboard interface and the address/sample sequencer.

---
 rtl/audio_key_controller_if.sv | 24 ++
 rtl/audio_key_controller.sv | 133 +++++++++++++
 2 files changed

// File: rtl/audio_key_controller_if.sv
// Command/status bundle between the PS/2 front end and the audio key controller.
// The master drives scan codes; the slave (controller) returns playback status and pacing.
interface audio_key_controller_if #(
  parameter int DIV_W = 16
);
  logic [7:0]       keyboard_in;
  logic             key_strobe;
  logic             play;
  logic             forward_backward;
  logic [7:0]       key_out;
  logic             sample_tick;
  logic             restart;
  logic [DIV_W-1:0] period;

  modport master (
    output keyboard_in, key_strobe,
    input  play, forward_backward, key_out, sample_tick, restart, period
  );

  modport slave (
    input  keyboard_in, key_strobe,
    output play, forward_backward, key_out, sample_tick, restart, period
  );
endinterface

// File: rtl/audio_key_controller.sv
// Decodes PS/2 scan codes into play/pause, direction, restart and speed commands,
// and paces the sample path with a programmable-period tick while playing.
module audio_key_controller #(
  parameter bit         EDGE_MODE   = 1'b0,
  parameter int         DIV_W       = 16,
  parameter int         BASE_DIV    = 2272,
  parameter int         STEP_DIV    = 227,
  parameter int         MIN_DIV     = 1136,
  parameter int         MAX_DIV     = 4544,
  parameter logic [7:0] KEY_PLAY    = 8'h24,
  parameter logic [7:0] KEY_STOP    = 8'h23,
  parameter logic [7:0] KEY_FWD     = 8'h2B,
  parameter logic [7:0] KEY_BWD     = 8'h2C,
  parameter logic [7:0] KEY_RESTART = 8'h2D,
  parameter logic [7:0] KEY_FASTER  = 8'h3C,
  parameter logic [7:0] KEY_SLOWER  = 8'h3B,
  parameter logic [7:0] KEY_NORMAL  = 8'h31
) (
  input  logic                  clk,
  input  logic                  reset,
  audio_key_controller_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_PLAYING, S_PAUSED} state_t;

  localparam logic [DIV_W-1:0] L_BASE = DIV_W'(BASE_DIV);
  localparam logic [DIV_W:0]   L_STEP = (DIV_W+1)'(STEP_DIV);
  localparam logic [DIV_W:0]   L_MIN  = (DIV_W+1)'(MIN_DIV);
  localparam logic [DIV_W:0]   L_MAX  = (DIV_W+1)'(MAX_DIV);

  state_t           r_state, w_state_next;
  logic [7:0]       r_prev_key;
  logic [DIV_W-1:0] r_cnt, w_cnt_next;
  logic [DIV_W-1:0] r_period, w_period_next;
  logic             r_play, r_fwd, w_fwd_next;
  logic [7:0]       r_key_out, w_key_out_next;
  logic             r_tick, w_tick_next;
  logic             r_restart, w_restart_next;
  logic             w_accept;
  logic [DIV_W:0]   w_period_ext;
  logic [DIV_W:0]   w_period_up;

  assign w_accept     = EDGE_MODE ? (bus.keyboard_in != r_prev_key) : bus.key_strobe;
  assign w_period_ext = {1'b0, r_period};
  assign w_period_up  = w_period_ext + L_STEP;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_state_next   = r_state;
    w_fwd_next     = r_fwd;
    w_period_next  = r_period;
    w_cnt_next     = r_cnt;
    w_tick_next    = 1'b0;
    w_restart_next = 1'b0;

    // Tick decision uses the current state, so a stop key cannot swallow a due tick.
    if (r_state == S_PLAYING) begin
      if (r_cnt >= r_period - DIV_W'(1)) begin
        w_tick_next = 1'b1;
        w_cnt_next  = '0;
      end else begin
        w_cnt_next = r_cnt + DIV_W'(1);
      end
    end

    if (w_accept) begin
      if (r_state == S_IDLE) begin
        if (bus.keyboard_in == KEY_PLAY) begin
          w_state_next = S_PLAYING;
          w_cnt_next   = '0;
        end
      end else begin
        case (bus.keyboard_in)
          KEY_PLAY:    w_state_next = S_PLAYING;
          KEY_STOP:    w_state_next = S_PAUSED;
          KEY_FWD:     w_fwd_next   = 1'b1;
          KEY_BWD:     w_fwd_next   = 1'b0;
          KEY_RESTART: begin
            w_restart_next = 1'b1;
            w_cnt_next     = '0;
            w_tick_next    = 1'b0;
          end
          KEY_FASTER:
            w_period_next = (w_period_ext < L_MIN + L_STEP) ? L_MIN[DIV_W-1:0]
                                                            : r_period - L_STEP[DIV_W-1:0];
          KEY_SLOWER:
            w_period_next = (w_period_up > L_MAX) ? L_MAX[DIV_W-1:0] : w_period_up[DIV_W-1:0];
          KEY_NORMAL:  w_period_next = L_BASE;
          default:     ;
        endcase
      end
    end

    case (w_state_next)
      S_PLAYING: w_key_out_next = KEY_PLAY;
      S_PAUSED:  w_key_out_next = KEY_STOP;
      default:   w_key_out_next = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins over any key or tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_prev_key <= 8'h00;
      r_cnt      <= '0;
      r_period   <= L_BASE;
      r_play     <= 1'b0;
      r_fwd      <= 1'b1;
      r_key_out  <= 8'h00;
      r_tick     <= 1'b0;
      r_restart  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_prev_key <= bus.keyboard_in;
      r_cnt      <= w_cnt_next;
      r_period   <= w_period_next;
      r_play     <= (w_state_next == S_PLAYING);
      r_fwd      <= w_fwd_next;
      r_key_out  <= w_key_out_next;
      r_tick     <= w_tick_next;
      r_restart  <= w_restart_next;
    end
  end

  assign bus.play             = r_play;
  assign bus.forward_backward = r_fwd;
  assign bus.key_out          = r_key_out;
  assign bus.sample_tick      = r_tick;
  assign bus.restart          = r_restart;
  assign bus.period           = r_period;

endmodule
